// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam int unsigned PC_INCR   = 4;

  // Ceiling log2, usable in constant expressions for counter and pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for in-flight npc tags and the fetched
// instruction buffer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: storage is not reset; an entry is never read before the count says it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited request issue, response
// buffering with redirect drop, and the IF/ID pipeline register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instruction,
  output logic [XLEN-1:0] if_id_npc
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     in_use;
  logic            tag_empty, tag_full, buf_empty, buf_full;
  logic [XLEN-1:0] tag_npc, head_instr, head_npc;
  logic            fire, resp_live, advance, bypass, buf_push, buf_pop;
  logic            unused_status;

  // Credit covers both requests still in memory and instructions parked in the buffer.
  assign in_use         = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (drop_cnt == '0);
  assign advance        = !stall && !redirect_valid;
  assign bypass         = advance && buf_empty && resp_live;
  assign buf_push       = resp_live && !redirect_valid && !bypass;
  assign buf_pop        = advance && !buf_empty;
  assign unused_status  = &{1'b0, tag_empty, tag_full, tag_count, buf_full};

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fire),
    .push_data (pc + XLEN'(PC_INCR)),
    .pop       (resp_live),
    .pop_data  (tag_npc),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_buf_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data ({imem_resp_data, tag_npc}),
    .pop       (buf_pop),
    .pop_data  ({head_instr, head_npc}),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  // NOTE: reset is synchronous here, so rst_n is just the highest-priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc                <= RESET_PC;
      outstanding       <= '0;
      drop_cnt          <= '0;
      if_id_valid       <= 1'b0;
      if_id_instruction <= XLEN'(INSTR_NOP);
      if_id_npc         <= '0;
    end else if (redirect_valid) begin
      // Everything still in memory after this edge belongs to the wrong path.
      pc                <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding       <= outstanding - CW'(imem_resp_valid);
      drop_cnt          <= outstanding - CW'(imem_resp_valid);
      if_id_valid       <= 1'b0;
      if_id_instruction <= XLEN'(INSTR_NOP);
    end else begin
      if (fire) pc <= pc + XLEN'(PC_INCR);
      outstanding <= outstanding + CW'(fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (!stall) begin
        if (!buf_empty) begin
          if_id_valid       <= 1'b1;
          if_id_instruction <= head_instr;
          if_id_npc         <= head_npc;
        end else if (resp_live) begin
          if_id_valid       <= 1'b1;
          if_id_instruction <= imem_resp_data;
          if_id_npc         <= tag_npc;
        end else begin
          if_id_valid       <= 1'b0;
          if_id_instruction <= XLEN'(INSTR_NOP);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for streaming, stall, redirect
// and PC wrap, plus a ready-toggling ordering run against a memory model.
module tb_fetch_unit;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

  logic        clk, rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_id_valid;
  logic [31:0] if_id_instruction, if_id_npc;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_npc         (if_id_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] req_a;
    logic [31:0] npc;
  } vec_t;

  mreq_t mq[$];
  vec_t  vq[$];
  int    cyc, lat, errors, checks;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called with inputs settled: log any handshake, cross the edge, then
  // present this cycle's in-order response.
  task automatic tick();
    if (rst_n && imem_req_valid && imem_req_ready)
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset(input int latency, input logic ready);
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = ready;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    lat             = latency;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  function automatic void add(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic [31:0] req_a, input logic [31:0] npc);
    vq.push_back('{st: st, rd: rd, rpc: rpc, req_a: req_a, npc: npc});
  endfunction

  task automatic run_vecs(input string name);
    string t;
    foreach (vq[i]) begin
      stall          = vq[i].st;
      redirect_valid = vq[i].rd;
      redirect_pc    = vq[i].rpc;
      #1;
      t = $sformatf("%s.c%0d", name, i);
      check({t, ".req_v"}, 32'(imem_req_valid), 32'(vq[i].req_a != NONE));
      if (vq[i].req_a != NONE) check({t, ".req_a"}, imem_req_addr, vq[i].req_a);
      check({t, ".if_v"}, 32'(if_id_valid), 32'(vq[i].npc != NONE));
      if (vq[i].npc != NONE) begin
        check({t, ".npc"}, if_id_npc, vq[i].npc);
        check({t, ".ins"}, if_id_instruction, mem_word(vq[i].npc - 32'd4));
      end else begin
        check({t, ".nop"}, if_id_instruction, 32'h0);
      end
      tick();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] exp_a, exp_n;
    errors = 0;
    checks = 0;
    cyc    = 0;
    lat    = 1;

    // Reset, 1-cycle memory streaming, then a 3-cycle stall.
    do_reset(1, 1'b1);
    check("rst.npc", if_id_npc, 32'h0);
    add(0, 0, 0, 32'h100, NONE);
    add(0, 0, 0, 32'h104, NONE);
    add(0, 0, 0, 32'h108, 32'h104);
    add(0, 0, 0, 32'h10C, 32'h108);
    add(0, 0, 0, 32'h110, 32'h10C);
    add(1, 0, 0, 32'h114, 32'h110);
    add(1, 0, 0, NONE,    32'h110);
    add(1, 0, 0, NONE,    32'h110);
    add(0, 0, 0, NONE,    32'h110);
    add(0, 0, 0, 32'h118, 32'h114);
    add(0, 0, 0, 32'h11C, 32'h118);
    add(0, 0, 0, 32'h120, 32'h11C);
    add(0, 0, 0, 32'h124, 32'h120);
    run_vecs("stream");

    // Redirect with two requests in a 3-cycle memory: both responses dropped.
    do_reset(3, 1'b1);
    add(0, 0, 0,          32'h100, NONE);
    add(0, 0, 0,          32'h104, NONE);
    add(0, 1, 32'h400,    NONE,    NONE);
    add(0, 0, 0,          NONE,    NONE);
    add(0, 0, 0,          32'h400, NONE);
    add(0, 0, 0,          32'h404, NONE);
    add(0, 0, 0,          NONE,    NONE);
    add(0, 0, 0,          NONE,    NONE);
    add(0, 0, 0,          32'h408, 32'h404);
    add(0, 0, 0,          32'h40C, 32'h408);
    run_vecs("redir");

    // Redirect with stall in the same cycle; unaligned target is word-aligned.
    do_reset(1, 1'b1);
    add(0, 0, 0,          32'h100, NONE);
    add(0, 0, 0,          32'h104, NONE);
    add(0, 0, 0,          32'h108, 32'h104);
    add(0, 0, 0,          32'h10C, 32'h108);
    add(1, 1, 32'h802,    NONE,    32'h10C);
    add(0, 0, 0,          32'h800, NONE);
    add(0, 0, 0,          32'h804, NONE);
    add(0, 0, 0,          32'h808, 32'h804);
    add(0, 0, 0,          32'h80C, 32'h808);
    run_vecs("rdstall");

    // PC wrap at the top of the address space, then reset mid-burst.
    do_reset(1, 1'b1);
    add(0, 0, 0,            32'h100,      NONE);
    add(0, 0, 0,            32'h104,      NONE);
    add(0, 0, 0,            32'h108,      32'h104);
    add(0, 0, 0,            32'h10C,      32'h108);
    add(0, 1, 32'hFFFF_FFFC, NONE,        32'h10C);
    add(0, 0, 0,            32'hFFFF_FFFC, NONE);
    add(0, 0, 0,            32'h0,        NONE);
    add(0, 0, 0,            32'h4,        32'h0);
    add(0, 0, 0,            32'h8,        32'h4);
    run_vecs("wrap");
    rst_n = 1'b0;
    #1;
    check("midrst.req_v_low", 32'(imem_req_valid), 32'd0);
    tick();
    check("midrst.if_v", 32'(if_id_valid), 32'd0);
    check("midrst.ins", if_id_instruction, 32'h0);
    check("midrst.npc", if_id_npc, 32'h0);
    check("midrst.req_v", 32'(imem_req_valid), 32'd0);
    do_reset(1, 1'b1);
    #1;
    check("postrst.req_a", imem_req_addr, 32'h100);

    // Random ready: address moves only on handshake, delivery order kept.
    do_reset(1, 1'b0);
    exp_a = 32'h100;
    exp_n = 32'h104;
    seen  = 0;
    for (int i = 0; i < 80; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      if (imem_req_valid) check($sformatf("rnd.req_a%0d", i), imem_req_addr, exp_a);
      if (if_id_valid) begin
        check($sformatf("rnd.npc%0d", i), if_id_npc, exp_n);
        check($sformatf("rnd.ins%0d", i), if_id_instruction, mem_word(exp_n - 32'd4));
        exp_n += 32'd4;
        seen++;
      end
      if (imem_req_valid && imem_req_ready) exp_a += 32'd4;
      tick();
    end
    check("rnd.delivered_enough", 32'(seen >= 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the 5-stage pipeline, and the successor to the single-cycle fetch path.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel, accepting in-order responses of arbitrary latency.
- Buffers up to DEPTH fetched instructions and drives the IF/ID pipeline register.
- Supports hazard-unit stalls and EX/MEM branch redirects, with flush of in-flight and buffered instructions.

## Interface
- XLEN, 32, instruction and address width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, power of two ≥ 2; maximum of outstanding requests plus buffered instructions.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect_valid  in  1  EX/MEM PC source select (branch/jump taken).
- redirect_pc  in  XLEN  EX/MEM target address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address (current PC).
- imem_resp_valid  in  1  response data valid; in request order.
- imem_resp_data  in  XLEN  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instruction  out  XLEN  IF/ID instruction.
- if_id_npc  out  XLEN  address of that instruction + 4.

## Operation
- Reset (rst_n low at an edge) sets:
  - pc = RESET_PC.
  - outstanding, drop_cnt and buffer occupancy = 0.
  - if_id_valid = 0, if_id_instruction = NOP (0), if_id_npc = 0.
  - imem_req_valid is forced 0 while rst_n is low.
- Issue: imem_req_valid = !redirect_valid && (outstanding + occupancy < DEPTH). imem_req_addr = pc.
- On handshake (valid && ready): pc += 4, wrapping modulo 2^XLEN. The pair {instr addr+4} is tagged into a side FIFO for the npc.
- Response:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise the response enters the buffer with its npc.
  - outstanding decrements on every response, dropped or not.
- IF/ID update when !stall && !redirect_valid:
  - If the buffer is non-empty, load the head and set valid = 1.
  - Else, if a non-dropped response arrives this cycle, bypass it directly.
  - Else, load a bubble: valid = 0, instruction = NOP.
  - When stall is high, IF/ID and the buffer head are held.
- Redirect (redirect_valid at edge):
  - pc = redirect_pc.
  - Buffer emptied.
  - drop_cnt = outstanding minus any response consumed that cycle.
  - IF/ID flushed to a bubble.
  - No request is issued in the redirect cycle.
- Redirect overrides stall. Redirect overrides a response arriving the same cycle; that response is dropped.
- Request issue and response in the same cycle: outstanding is unchanged.
- redirect_pc is word-aligned by contract. The low 2 bits are forced to 0.

## Timing
- Request handshake at cycle t with a 1-cycle memory: response in t+1, and if_id_valid is high in t+2 (bypass path, no stall).
- Zero-wait memory (ready always high, 1-cycle response) sustains one instruction per cycle with DEPTH ≥ 2.
- Redirect asserted in cycle r:
  - if_id_valid = 0 in r+1.
  - First request to redirect_pc in r+1.
  - First target instruction in IF/ID in r+3 at the earliest.
- Stall asserted in cycle s: IF/ID unchanged in s+1. Fetch continues until the DEPTH credit is exhausted.
- First request is issued in the first cycle with rst_n high.

## Structure
- Package fetch_pkg:
  - INSTR_NOP constant.
  - PC_INCR = 4.
  - Function clog2 for counter widths; counters are clog2(DEPTH)+1 bits.
- Sub-module fetch_fifo: synchronous FIFO of {instruction, npc}. It has push, pop, flush, empty, full and count, and is DEPTH entries deep.
- Top level holds the PC, outstanding/drop counters, issue logic and the IF/ID register.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory, ready=1: IF/ID sequence 0x100→npc 0x104, 0x108, 0x10C on consecutive cycles from cycle 2.
- Stall held 3 cycles mid-stream: IF/ID constant; no more than DEPTH requests outstanding plus buffered; stream resumes with no loss or duplication.
- Redirect to 0x400 with 2 responses in flight (3-cycle memory): both dropped; next valid IF/ID has npc 0x404.
- Redirect and stall in the same cycle: IF/ID is a bubble next cycle, and PC = target.
- imem_req_ready toggling randomly: address increments only on handshake; instruction order is preserved.
- PC at 0xFFFF_FFFC: next fetch address 0x0000_0000, npc 0x0000_0000. Reset asserted mid-burst: all outputs return to reset values next cycle.
